flash_spi_shifter: RTL and testbench



---
 rtl/flash_pkg.sv | 14 +
 rtl/flash_spi_shifter_if.sv | 27 ++
 rtl/flash_spi_shifter.sv | 109 ++++++++++
 tb/tb_flash_spi_shifter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared constants for the configuration-flash SPI engine.
// State encoding, default FCK divider and byte width.
package flash_pkg;

  localparam int BYTE_W = 8;
  localparam int CLKDIV_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/flash_spi_shifter_if.sv
// Host/flash signal bundle for flash_spi_shifter.
// master = host side driving requests, slave = shifter.
interface flash_spi_shifter_if;
  import flash_pkg::*;

  logic              enable;
  logic              start;
  logic [BYTE_W-1:0] txdata;
  logic [BYTE_W-1:0] rxdata;
  logic              busy;
  logic              done;
  logic              si;
  logic              so;
  logic              fck;
  logic              fcs;

  modport master (
    output enable, start, txdata, si,
    input  rxdata, busy, done, so, fck, fcs
  );

  modport slave (
    input  enable, start, txdata, si,
    output rxdata, busy, done, so, fck, fcs
  );

endinterface

// File: rtl/flash_spi_shifter.sv
// Byte-serial SPI mode-0 master for the configuration flash.
// Shifts TXDATA out MSB-first on SO/FCK, captures SI into RXDATA.
module flash_spi_shifter
  import flash_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  flash_spi_shifter_if.slave bus
);

  localparam int DW = $clog2(CLKDIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  state_t            state;
  logic [DW-1:0]     div;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] sr;

  logic div_end;
  logic load;

  assign div_end = (div == DIV_LAST);
  assign load    = bus.start && bus.enable;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      bus.fck    <= 1'b0;
      bus.so     <= 1'b0;
      bus.fcs    <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.rxdata <= '0;
    end else begin
      bus.fcs  <= ~bus.enable;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.fck <= 1'b0;
          if (load) begin
            sr       <= bus.txdata;
            bus.so   <= bus.txdata[BYTE_W-1];
            bit_cnt  <= '0;
            div      <= '0;
            bus.busy <= 1'b1;
            state    <= LOW;
          end
        end
        LOW: begin
          if (!bus.enable) begin
            state    <= IDLE;
            div      <= '0;
            bus.fck  <= 1'b0;
            bus.busy <= 1'b0;
          end else if (div_end) begin
            div     <= '0;
            bus.fck <= 1'b1;
            sr      <= {sr[BYTE_W-2:0], bus.si};
            state   <= HIGH;
          end else begin
            div <= div + 1'b1;
          end
        end
        HIGH: begin
          if (!bus.enable) begin
            state    <= IDLE;
            div      <= '0;
            bus.fck  <= 1'b0;
            bus.busy <= 1'b0;
          end else if (div_end) begin
            div     <= '0;
            bus.fck <= 1'b0;
            if (bit_cnt == 3'd7) begin
              bus.rxdata <= sr;
              bus.done   <= 1'b1;
              // a start landing on the final edge chains the next byte
              if (bus.start) begin
                sr      <= bus.txdata;
                bus.so  <= bus.txdata[BYTE_W-1];
                bit_cnt <= '0;
                state   <= LOW;
              end else begin
                bus.busy <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              bus.so  <= sr[BYTE_W-1];
              state   <= LOW;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.fck  <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_spi_shifter.sv
// Randomized bench for flash_spi_shifter against a byte-level flash model.
// Two instances: CLKDIV=2 for single-byte cases, CLKDIV=1 for chaining.
module tb_flash_spi_shifter;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  flash_spi_shifter_if ifa ();
  flash_spi_shifter_if ifb ();

  flash_spi_shifter #(.CLKDIV(2)) ua (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ifa)
  );

  flash_spi_shifter #(.CLKDIV(1)) ub (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // si_mode: 0 loopback, 1 tied low, 2 tied high, 3 flash reply byte
  logic [1:0] si_mode;
  logic [7:0] rbyte;
  int         rises_a;

  assign ifa.si = (si_mode == 2'd0) ? ifa.so :
                  (si_mode == 2'd1) ? 1'b0 :
                  (si_mode == 2'd2) ? 1'b1 :
                  rbyte[3'd7 - rises_a[2:0]];
  assign ifb.si = ifb.so;

  logic       mon_clr;
  logic       fck_prev;
  logic [7:0] so_acc;
  int         hi_a, busy_a, done_a;

  always @(negedge clk) begin
    fck_prev <= ifa.fck;
    if (mon_clr) begin
      rises_a <= 0;
      so_acc  <= 8'h00;
      hi_a    <= 0;
      busy_a  <= 0;
      done_a  <= 0;
    end else begin
      if (ifa.fck && !fck_prev) begin
        rises_a <= rises_a + 1;
        so_acc  <= {so_acc[6:0], ifa.so};
      end
      if (ifa.fck)  hi_a   <= hi_a + 1;
      if (ifa.busy) busy_a <= busy_a + 1;
      if (ifa.done) done_a <= done_a + 1;
    end
  end

  logic       mon_clr_b;
  int         done_b, fcs_hi_b, t1, t2;
  logic [7:0] rx1, rx2;

  always @(negedge clk) begin
    if (mon_clr_b) begin
      done_b   <= 0;
      fcs_hi_b <= 0;
      t1       <= 0;
      t2       <= 0;
      rx1      <= 8'h00;
      rx2      <= 8'h00;
    end else begin
      if (ifb.fcs) fcs_hi_b <= fcs_hi_b + 1;
      if (ifb.done) begin
        done_b <= done_b + 1;
        if (done_b == 0) begin
          t1  <= cyc;
          rx1 <= ifb.rxdata;
        end else begin
          t2  <= cyc;
          rx2 <= ifb.rxdata;
        end
      end
    end
  end

  logic [7:0] exp_rx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a();
    int i;
    i = 0;
    while (!ifa.done && i < 200) begin
      tick();
      i++;
    end
    tick();
  endtask

  task automatic run_a(input logic [7:0] tx);
    mon_clr    = 1'b1;
    ifa.start  = 1'b1;
    ifa.txdata = tx;
    tick();
    ifa.start  = 1'b0;
    mon_clr    = 1'b0;
    wait_done_a();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.enable = 1'b0;
    ifa.start  = 1'b0;
    ifa.txdata = 8'h00;
    ifb.enable = 1'b0;
    ifb.start  = 1'b0;
    ifb.txdata = 8'h00;
    si_mode    = 2'd0;
    rbyte      = 8'h00;
    mon_clr    = 1'b1;
    mon_clr_b  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_vec += 6;
    if (ifa.fck !== 1'b0) begin
      n_err++; $display("FAIL reset_fck got %b want 0", ifa.fck);
    end
    if (ifa.so !== 1'b0) begin
      n_err++; $display("FAIL reset_so got %b want 0", ifa.so);
    end
    if (ifa.fcs !== 1'b1) begin
      n_err++; $display("FAIL reset_fcs got %b want 1", ifa.fcs);
    end
    if (ifa.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b want 0", ifa.busy);
    end
    if (ifa.done !== 1'b0) begin
      n_err++; $display("FAIL reset_done got %b want 0", ifa.done);
    end
    if (ifa.rxdata !== 8'h00) begin
      n_err++; $display("FAIL reset_rx got %h want 00", ifa.rxdata);
    end
    exp_rx = 8'h00;
    ifa.enable = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_loopback();
    si_mode = 2'd0;
    run_a(8'hA5);
    exp_rx = 8'hA5;
    n_vec += 6;
    if (busy_a !== 32) begin
      n_err++; $display("FAIL lb_busy_cycles got %0d want 32", busy_a);
    end
    if (rises_a !== 8) begin
      n_err++; $display("FAIL lb_fck_pulses got %0d want 8", rises_a);
    end
    if (hi_a !== 16) begin
      n_err++; $display("FAIL lb_fck_high got %0d want 16", hi_a);
    end
    if (so_acc !== 8'hA5) begin
      n_err++; $display("FAIL lb_so_stream got %h want a5", so_acc);
    end
    if (done_a !== 1) begin
      n_err++; $display("FAIL lb_done_pulses got %0d want 1", done_a);
    end
    if (ifa.rxdata !== exp_rx) begin
      n_err++; $display("FAIL lb_rx got %h want %h", ifa.rxdata, exp_rx);
    end
  endtask

  task automatic test_const_si();
    si_mode = 2'd2;
    run_a(8'h03);
    exp_rx = 8'hFF;
    n_vec++;
    if (ifa.rxdata !== exp_rx) begin
      n_err++; $display("FAIL si_high_rx got %h want %h", ifa.rxdata, exp_rx);
    end
    si_mode = 2'd1;
    run_a(8'hFF);
    exp_rx = 8'h00;
    n_vec++;
    if (ifa.rxdata !== exp_rx) begin
      n_err++; $display("FAIL si_low_rx got %h want %h", ifa.rxdata, exp_rx);
    end
  endtask

  task automatic test_random();
    logic [7:0] tx;
    si_mode = 2'd3;
    for (int n = 0; n < 6; n++) begin
      tx    = 8'($urandom);
      rbyte = 8'($urandom);
      run_a(tx);
      exp_rx = rbyte;
      n_vec += 2;
      if (so_acc !== tx) begin
        n_err++; $display("FAIL rnd_so[%0d] got %h want %h", n, so_acc, tx);
      end
      if (ifa.rxdata !== exp_rx) begin
        n_err++;
        $display("FAIL rnd_rx[%0d] got %h want %h", n, ifa.rxdata, exp_rx);
      end
    end
  endtask

  task automatic test_start_while_busy();
    si_mode    = 2'd0;
    mon_clr    = 1'b1;
    ifa.start  = 1'b1;
    ifa.txdata = 8'hC3;
    tick();
    ifa.start = 1'b0;
    mon_clr   = 1'b0;
    repeat (10) tick();
    ifa.start  = 1'b1;
    ifa.txdata = 8'h00;
    tick();
    ifa.start = 1'b0;
    wait_done_a();
    exp_rx = 8'hC3;
    n_vec += 4;
    if (so_acc !== 8'hC3) begin
      n_err++; $display("FAIL busy_so got %h want c3", so_acc);
    end
    if (ifa.rxdata !== exp_rx) begin
      n_err++; $display("FAIL busy_rx got %h want %h", ifa.rxdata, exp_rx);
    end
    if (done_a !== 1) begin
      n_err++; $display("FAIL busy_done got %0d want 1", done_a);
    end
    if (busy_a !== 32) begin
      n_err++; $display("FAIL busy_cycles got %0d want 32", busy_a);
    end
  endtask

  task automatic test_abort();
    int i;
    si_mode    = 2'd0;
    mon_clr    = 1'b1;
    ifa.start  = 1'b1;
    ifa.txdata = 8'h5A;
    tick();
    ifa.start = 1'b0;
    mon_clr   = 1'b0;
    i = 0;
    while (rises_a < 3 && i < 100) begin
      tick();
      i++;
    end
    ifa.enable = 1'b0;
    tick();
    n_vec += 5;
    if (ifa.fck !== 1'b0) begin
      n_err++; $display("FAIL abort_fck got %b want 0", ifa.fck);
    end
    if (ifa.busy !== 1'b0) begin
      n_err++; $display("FAIL abort_busy got %b want 0", ifa.busy);
    end
    if (ifa.fcs !== 1'b1) begin
      n_err++; $display("FAIL abort_fcs got %b want 1", ifa.fcs);
    end
    repeat (40) tick();
    if (done_a !== 0) begin
      n_err++; $display("FAIL abort_done got %0d want 0", done_a);
    end
    if (ifa.rxdata !== exp_rx) begin
      n_err++; $display("FAIL abort_rx got %h want %h", ifa.rxdata, exp_rx);
    end
    ifa.enable = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    si_mode    = 2'd0;
    mon_clr    = 1'b1;
    ifa.start  = 1'b1;
    ifa.txdata = 8'hFF;
    tick();
    ifa.start = 1'b0;
    mon_clr   = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    exp_rx = 8'h00;
    n_vec += 6;
    if (ifa.fck !== 1'b0) begin
      n_err++; $display("FAIL rstmid_fck got %b want 0", ifa.fck);
    end
    if (ifa.so !== 1'b0) begin
      n_err++; $display("FAIL rstmid_so got %b want 0", ifa.so);
    end
    if (ifa.fcs !== 1'b1) begin
      n_err++; $display("FAIL rstmid_fcs got %b want 1", ifa.fcs);
    end
    if (ifa.busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_busy got %b want 0", ifa.busy);
    end
    if (ifa.rxdata !== exp_rx) begin
      n_err++; $display("FAIL rstmid_rx got %h want %h", ifa.rxdata, exp_rx);
    end
    rst = 1'b0;
    repeat (40) tick();
    if (done_a !== 0) begin
      n_err++; $display("FAIL rstmid_done got %0d want 0", done_a);
    end
  endtask

  task automatic test_back_to_back();
    int k, i;
    ifb.enable = 1'b1;
    repeat (2) tick();
    mon_clr_b  = 1'b1;
    ifb.start  = 1'b1;
    ifb.txdata = 8'h9F;
    tick();
    k = cyc;
    ifb.start = 1'b0;
    mon_clr_b = 1'b0;
    repeat (15) tick();
    ifb.start  = 1'b1;
    ifb.txdata = 8'h12;
    tick();
    ifb.start = 1'b0;
    i = 0;
    while (done_b < 2 && i < 100) begin
      tick();
      i++;
    end
    tick();
    n_vec += 6;
    if (done_b !== 2) begin
      n_err++; $display("FAIL b2b_done got %0d want 2", done_b);
    end
    if (t1 !== k + 16) begin
      n_err++; $display("FAIL b2b_t1 got %0d want %0d", t1, k + 16);
    end
    if (t2 - t1 !== 16) begin
      n_err++; $display("FAIL b2b_gap got %0d want 16", t2 - t1);
    end
    if (rx1 !== 8'h9F) begin
      n_err++; $display("FAIL b2b_rx1 got %h want 9f", rx1);
    end
    if (rx2 !== 8'h12) begin
      n_err++; $display("FAIL b2b_rx2 got %h want 12", rx2);
    end
    if (fcs_hi_b !== 0) begin
      n_err++; $display("FAIL b2b_fcs got %0d high cycles want 0", fcs_hi_b);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_const_si();
    test_random();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
